st2bus: RTL and testbench
=========================

Name: st2bus

Overview:
- Return-path packer for the NLB AFU turbo decoder.
- Accepts the decoder's Avalon-ST hard-decision output, one ST-bit beat per cycle, and packs the beats LSB-first into BUS-bit words.
- Emits the words on a valid/ready parallel bus to the memory write engine, with per-packet last and error marking.
- Single clock domain (clk_bus); the decoder output is brought into clk_bus by the upstream dual-clock FIFO.

Parameters:
- BUS, 512, output bus word width in bits.
- ST, 8, Avalon-ST data width in bits; BUS must be an integer multiple of ST.
- ST_PER_BUS, 64, beats per bus word (BUS/ST).
- FIFO_DEPTH, 2, output word buffer depth; power of 2, minimum 2.

Ports:
- clk_bus  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- st_data  in  ST  decoder output beat.
- st_valid  in  1  beat valid.
- st_sop  in  1  first beat of a packet.
- st_eop  in  1  last beat of a packet.
- st_error  in  1  decoder error; sampled on any accepted beat.
- st_ready  out  1  packer can accept a beat this cycle.
- bus_data  out  BUS  packed word; beat k of the word occupies bits [k*ST+ST-1 : k*ST].
- bus_valid  out  1  bus_data is valid.
- bus_last  out  1  word is the last of its packet.
- bus_err  out  1  packet containing this word is errored or malformed.
- bus_ready  in  1  downstream accepts the word when bus_valid and bus_ready are both high.

Behaviour:
- Beat acceptance: accept = st_valid & st_ready.
- st_ready = (fifo_count < FIFO_DEPTH) & rst_n.
  - st_ready is registered-path only; it has no combinational dependency on st_valid.
- States:
  - IDLE: waiting for sop. An accepted beat with st_sop=1 loads beat 0, sets beat_cnt=1 and goes to PACK. An accepted beat with st_sop=0 is dropped and sets sticky orphan_seen.
  - PACK: each accepted beat is written at slot beat_cnt, then beat_cnt increments.
- Word completion, checked on each accepted beat in this order:
  1. sop while in PACK (missing eop): push the partial word with last=1, err=1. Clear the shift register, load the new beat at slot 0, set beat_cnt=1, stay in PACK.
  2. eop: push the word (unfilled upper slots are zero) with last=1 and err = pkt_err | st_error. Return to IDLE, beat_cnt=0.
  3. beat_cnt == ST_PER_BUS-1: push a full word with last=0 and err=pkt_err|st_error. Set beat_cnt=0, stay in PACK.
- sop and eop on the same beat: a one-beat packet. Push one word with data in bits [ST-1:0], last=1. State ends in IDLE.
- pkt_err: sticky within a packet. Set by st_error on any accepted beat; cleared on the push with last=1.
- The shift register is cleared to zero after every push.
- Output buffer: a FIFO of {data, last, err}.
  - bus_valid = fifo not empty; bus_data, bus_last and bus_err come from the FIFO head.
  - Pop happens on bus_valid & bus_ready.
  - Push and pop in the same cycle leave the count unchanged.
- Latency: the beat that completes a word is accepted in cycle N; bus_valid is high in cycle N+1 if the FIFO was empty.
- Full condition: while the FIFO is full, st_ready=0. No beat is lost and no word is overwritten.
- Held outputs: under backpressure, bus_data, bus_last and bus_err hold stable while bus_valid=1 and bus_ready=0.
- Reset (rst_n=0), including mid-packet:
  - state=IDLE, beat_cnt=0, shift register=0, pkt_err=0, orphan_seen=0.
  - FIFO emptied.
  - Outputs: bus_valid=0, bus_last=0, bus_err=0, bus_data=0, st_ready=0.
  - The partial packet is discarded, and the first beat after reset release must carry sop.
- Width rules: beat_cnt is $clog2(ST_PER_BUS) bits and wraps only via the rules above; fifo_count is $clog2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro ST2BUS_STATS_EN. When defined, two output ports are added, both reset to 0 and wrapping at 2^16-1 -> 0:
  - pkt_cnt (16 bits): increments on each pop of a word with bus_last=1.
  - err_cnt (16 bits): increments on each pop of a word with bus_last=1 and bus_err=1, and on each dropped orphan beat.
- When undefined, neither port nor its counters exist. orphan_seen remains internal only.

Test Plan:
- Full-length packet, bus_ready=1: 128 beats, data = beat index mod 256 -> 2 words. Word0 byte k = k, word1 byte k = 64+k. bus_last = 0 then 1; bus_err=0.
- Short packet: 3 beats 0xA1, 0xB2, 0xC3 -> one word 0x...00C3B2A1 with upper bits zero, bus_last=1, issued 1 cycle after the eop beat.
- Backpressure: bus_ready=0, stream 256 beats -> exactly 2 words buffered and st_ready=0 from the cycle after the second push. Raise bus_ready -> 4 words in order, none lost, and bus_data stable while stalled.
- Malformed traffic:
  - sop at beat 10 of a packet with no eop -> word with 10 beats, last=1, err=1, followed by the new packet's words.
  - A beat without sop in IDLE -> no word emitted (err_cnt=1 when ST2BUS_STATS_EN is defined).
- Error and sop+eop:
  - st_error=1 on beat 5 of a 70-beat packet -> both words have bus_err=1.
  - A sop+eop single beat 0x5A -> one word = 0x5A, last=1.
- Reset mid-packet: rst_n=0 after 30 beats, 1 cycle -> bus_valid=0, st_ready=0 during reset. The next 64-beat packet is emitted as one clean word with no residue from the discarded packet.

Source files
------------

// File: rtl/st2bus_if.sv
// st2bus handshake bundle: decoder Avalon-ST side plus packed-word bus side.
// master = packer view, slave = environment view.
interface st2bus_if #(
  parameter int BUS = 512,
  parameter int ST  = 8
);
  logic [ST-1:0]  st_data;
  logic           st_valid;
  logic           st_sop;
  logic           st_eop;
  logic           st_error;
  logic           st_ready;
  logic [BUS-1:0] bus_data;
  logic           bus_valid;
  logic           bus_last;
  logic           bus_err;
  logic           bus_ready;

  modport master (
    input  st_data, st_valid, st_sop, st_eop, st_error, bus_ready,
    output st_ready, bus_data, bus_valid, bus_last, bus_err
  );

  modport slave (
    output st_data, st_valid, st_sop, st_eop, st_error, bus_ready,
    input  st_ready, bus_data, bus_valid, bus_last, bus_err
  );
endinterface

// File: rtl/st2bus.sv
// Packs ST-bit decoder beats LSB-first into BUS-bit words behind a small FIFO.
// Define ST2BUS_STATS_EN to add pkt_cnt/err_cnt statistics outputs.
module st2bus #(
  parameter int BUS        = 512,
  parameter int ST         = 8,
  parameter int ST_PER_BUS = BUS / ST,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_bus,
  input  logic        rst_n,
  st2bus_if.master    io
`ifdef ST2BUS_STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int CW = $clog2(ST_PER_BUS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(ST_PER_BUS - 1);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, PACK} state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [BUS-1:0] sr_q;
  logic           perr_q;
  logic           orphan_q;

  logic [BUS-1:0]        dmem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] lmem_q;
  logic [FIFO_DEPTH-1:0] emem_q;
  logic [PW-1:0]         wp_q;
  logic [PW-1:0]         rp_q;
  logic [PW:0]           fcnt_q;

  logic           accept;
  logic           pop;
  logic           fvalid;
  logic [BUS-1:0] beat_w;
  logic [BUS-1:0] ins_w;
  logic           push_w;
  logic [BUS-1:0] push_d;
  logic           push_l;
  logic           push_e;
  logic           drop_w;

  assign fvalid      = (fcnt_q != '0);
  assign io.st_ready = (fcnt_q < DEPTH_C) & rst_n;
  assign accept      = io.st_valid & io.st_ready;
  assign pop         = fvalid & io.bus_ready;

  assign io.bus_valid = fvalid;
  assign io.bus_data  = fvalid ? dmem_q[rp_q] : '0;
  assign io.bus_last  = fvalid & lmem_q[rp_q];
  assign io.bus_err   = fvalid & emem_q[rp_q];

  assign beat_w = BUS'(io.st_data);
  assign ins_w  = sr_q | (beat_w << (ST * int'(cnt_q)));

  // Word completion priority: restart-sop, then eop, then full word.
  always_comb begin
    push_w = 1'b0;
    push_d = ins_w;
    push_l = 1'b0;
    push_e = perr_q | io.st_error;
    drop_w = 1'b0;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (!io.st_sop) begin
            drop_w = 1'b1;
          end else if (io.st_eop) begin
            push_w = 1'b1;
            push_d = beat_w;
            push_l = 1'b1;
          end
        end
        PACK: begin
          if (io.st_sop) begin
            push_w = 1'b1;
            push_d = sr_q;
            push_l = 1'b1;
            push_e = 1'b1;
          end else if (io.st_eop) begin
            push_w = 1'b1;
            push_l = 1'b1;
          end else if (cnt_q == LAST_C) begin
            push_w = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_bus) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      perr_q   <= 1'b0;
      orphan_q <= 1'b0;
      wp_q     <= '0;
      rp_q     <= '0;
      fcnt_q   <= '0;
      lmem_q   <= '0;
      emem_q   <= '0;
    end else begin
      if (accept) begin
        unique case (state_q)
          IDLE: begin
            if (!io.st_sop) begin
              orphan_q <= 1'b1;
            end else if (!io.st_eop) begin
              state_q <= PACK;
              sr_q    <= beat_w;
              cnt_q   <= CW'(1);
              perr_q  <= io.st_error;
            end
          end
          PACK: begin
            if (io.st_sop) begin
              sr_q   <= beat_w;
              cnt_q  <= CW'(1);
              perr_q <= io.st_error;
            end else if (io.st_eop) begin
              state_q <= IDLE;
              sr_q    <= '0;
              cnt_q   <= '0;
              perr_q  <= 1'b0;
            end else if (cnt_q == LAST_C) begin
              sr_q   <= '0;
              cnt_q  <= '0;
              perr_q <= perr_q | io.st_error;
            end else begin
              sr_q   <= ins_w;
              cnt_q  <= cnt_q + CW'(1);
              perr_q <= perr_q | io.st_error;
            end
          end
          default: ;
        endcase
      end
      if (push_w) begin
        dmem_q[wp_q] <= push_d;
        lmem_q[wp_q] <= push_l;
        emem_q[wp_q] <= push_e;
        wp_q         <= wp_q + PW'(1);
      end
      if (pop) begin
        rp_q <= rp_q + PW'(1);
      end
      fcnt_q <= fcnt_q + {{PW{1'b0}}, push_w} - {{PW{1'b0}}, pop};
    end
  end

  // Orphan flag is sticky until reset.
  a_orphan_sticky : assert property (
    @(posedge clk_bus) disable iff (!rst_n) orphan_q |=> orphan_q
  );

`ifdef ST2BUS_STATS_EN
  always_ff @(posedge clk_bus) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      pkt_cnt <= pkt_cnt + 16'(pop & io.bus_last);
      err_cnt <= err_cnt + 16'(pop & io.bus_last & io.bus_err)
                         + 16'(drop_w);
    end
  end
`endif

endmodule

// File: tb/tb_st2bus.sv
// Directed self-checking bench for st2bus.
// Builds with or without ST2BUS_STATS_EN.
module tb_st2bus;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  st2bus_if #(.BUS(512), .ST(8)) bif ();

`ifdef ST2BUS_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;
`endif

  st2bus #(
    .BUS(512), .ST(8), .ST_PER_BUS(64), .FIFO_DEPTH(2)
  ) dut (
    .clk_bus (clk),
    .rst_n   (rst_n),
    .io      (bif)
`ifdef ST2BUS_STATS_EN
    ,
    .pkt_cnt (pkt_cnt),
    .err_cnt (err_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  int acc   = 0;

  logic [511:0] got_d [$];
  bit           got_l [$];
  bit           got_e [$];

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bif.bus_valid && bif.bus_ready) begin
      got_d.push_back(bif.bus_data);
      got_l.push_back(bif.bus_last);
      got_e.push_back(bif.bus_err);
    end
    if (bif.st_valid && bif.st_ready) acc++;
  end

  function automatic logic [511:0] ramp(input int base, input int n);
    logic [511:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[k*8 +: 8] = 8'((base + k) & 255);
    return w;
  endfunction

  task automatic clr();
    got_d.delete();
    got_l.delete();
    got_e.delete();
  endtask

  task automatic beat(input logic [7:0] d, input bit s, input bit e,
                      input bit er);
    int t;
    @(negedge clk);
    bif.st_valid = 1'b1;
    bif.st_data  = d;
    bif.st_sop   = s;
    bif.st_eop   = e;
    bif.st_error = er;
    t = 0;
    while (!bif.st_ready) begin
      @(negedge clk);
      t++;
      if (t > 2000) begin
        chk("ready_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bif.st_valid = 1'b0;
    bif.st_sop   = 1'b0;
    bif.st_eop   = 1'b0;
    bif.st_error = 1'b0;
  endtask

  task automatic pkt(input int base, input int n, input bit s,
                     input bit e, input int err_at);
    for (int i = 0; i < n; i++)
      beat(8'((base + i) & 255), s && i == 0, e && i == n - 1,
           i == err_at);
  endtask

  task automatic word(input string tag, input int idx,
                      input logic [511:0] d, input bit l, input bit e);
    if (idx < got_d.size()) begin
      chk({tag, "_data"}, got_d[idx], d);
      chk({tag, "_last"}, 512'(got_l[idx]), 512'(l));
      chk({tag, "_err"},  512'(got_e[idx]), 512'(e));
    end else begin
      chk({tag, "_missing"}, 512'(got_d.size()), 512'(idx + 1));
    end
  endtask

  initial begin
    bif.st_valid  = 1'b0;
    bif.st_data   = '0;
    bif.st_sop    = 1'b0;
    bif.st_eop    = 1'b0;
    bif.st_error  = 1'b0;
    bif.bus_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_valid", 512'(bif.bus_valid), 0);
    chk("rst_ready", 512'(bif.st_ready), 0);
    chk("rst_data",  bif.bus_data, 0);
    chk("rst_last",  512'(bif.bus_last), 0);
    chk("rst_err",   512'(bif.bus_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 512'(bif.st_ready), 1);

    // full-length 128-beat packet
    clr();
    pkt(0, 128, 1, 1, -1);
    idle();
    repeat (5) @(negedge clk);
    chk("full_cnt", 512'(got_d.size()), 2);
    word("full_w0", 0, ramp(0, 64), 0, 0);
    word("full_w1", 1, ramp(64, 64), 1, 0);
`ifdef ST2BUS_STATS_EN
    chk("stats_pkt", 512'(pkt_cnt), 1);
`endif

    // short packet and one-cycle latency
    clr();
    beat(8'hA1, 1, 0, 0);
    beat(8'hB2, 0, 0, 0);
    beat(8'hC3, 0, 1, 0);
    @(posedge clk);
    @(negedge clk);
    chk("short_lat_valid", 512'(bif.bus_valid), 1);
    chk("short_lat_data", bif.bus_data, 512'hC3B2A1);
    bif.st_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("short_cnt", 512'(got_d.size()), 1);
    word("short", 0, 512'hC3B2A1, 1, 0);

    // backpressure with 256 beats
    clr();
    bif.bus_ready = 1'b0;
    acc = 0;
    fork
      begin
        pkt(0, 256, 1, 1, -1);
        idle();
      end
      begin
        int t;
        t = 0;
        @(negedge clk);
        while (bif.st_ready && t < 1000) begin
          @(negedge clk);
          t++;
        end
        chk("bp_acc_at_stall", 512'(acc), 128);
        chk("bp_valid", 512'(bif.bus_valid), 1);
        chk("bp_hold0", bif.bus_data, ramp(0, 64));
        repeat (10) @(negedge clk);
        chk("bp_ready_low", 512'(bif.st_ready), 0);
        chk("bp_acc_held", 512'(acc), 128);
        chk("bp_hold1", bif.bus_data, ramp(0, 64));
        chk("bp_hold_last", 512'(bif.bus_last), 0);
        bif.bus_ready = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    chk("bp_cnt", 512'(got_d.size()), 4);
    word("bp_w0", 0, ramp(0, 64), 0, 0);
    word("bp_w1", 1, ramp(64, 64), 0, 0);
    word("bp_w2", 2, ramp(128, 64), 0, 0);
    word("bp_w3", 3, ramp(192, 64), 1, 0);

    // missing eop: sop arrives at beat 10
    clr();
    pkt(16, 10, 1, 0, -1);
    pkt(32, 3, 1, 1, -1);
    idle();
    repeat (4) @(negedge clk);
    chk("noeop_cnt", 512'(got_d.size()), 2);
    word("noeop_w0", 0, ramp(16, 10), 1, 1);
    word("noeop_w1", 1, ramp(32, 3), 1, 0);

    // orphan beat in IDLE
    clr();
    begin
`ifdef ST2BUS_STATS_EN
      logic [15:0] e0;
      e0 = err_cnt;
`endif
      beat(8'h77, 0, 1, 0);
      idle();
      repeat (4) @(negedge clk);
      chk("orphan_none", 512'(got_d.size()), 0);
`ifdef ST2BUS_STATS_EN
      chk("orphan_errcnt", 512'(err_cnt - e0), 1);
`endif
    end

    // error on beat 5 of a 70-beat packet, then sop+eop
    clr();
    pkt(0, 70, 1, 1, 5);
    beat(8'h5A, 1, 1, 0);
    idle();
    repeat (4) @(negedge clk);
    chk("err_cnt_words", 512'(got_d.size()), 3);
    word("err_w0", 0, ramp(0, 64), 0, 1);
    word("err_w1", 1, ramp(64, 6), 1, 1);
    word("single", 2, 512'h5A, 1, 0);

    // reset mid-packet
    clr();
    pkt(0, 30, 1, 0, -1);
    @(negedge clk);
    bif.st_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", 512'(bif.st_ready), 0);
    @(negedge clk);
    chk("mrst_valid", 512'(bif.bus_valid), 0);
    chk("mrst_ready2", 512'(bif.st_ready), 0);
    rst_n = 1'b1;
    pkt(192, 64, 1, 1, -1);
    idle();
    repeat (4) @(negedge clk);
    chk("mrst_cnt", 512'(got_d.size()), 1);
    word("mrst_w", 0, ramp(192, 64), 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
